// File: rtl/d5m_pattern_gen_if.sv
// Pixel-bus interface between the synthetic D5M source (master) and the VFP input port (slave).
// Frame/line valid carry no back-pressure: a pixel is consumed in every cycle ilval is high.
interface d5m_pattern_gen_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  enable;
   logic [1:0]            pattern_sel;
   logic                  ifval;
   logic                  ilval;
   logic [DATA_WIDTH-1:0] idata;
   logic                  frame_done;
   logic [15:0]           frame_cnt;

   modport master (
      input  enable, pattern_sel,
      output ifval, ilval, idata, frame_done, frame_cnt
   );

   modport slave (
      output enable, pattern_sel,
      input  ifval, ilval, idata, frame_done, frame_cnt
   );
endinterface

// File: rtl/d5m_pattern_gen.sv
// Synthetic D5M sensor: fval/lval framing with blanking and selectable raw test patterns.
// Optional macro D5M_PATTERN_LFSR_EN turns pattern 3 into an LFSR stream (else an 8x8 checker).
module d5m_pattern_gen #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 48,
   parameter int H_BLANK    = 16,
   parameter int V_BLANK    = 32
) (
   input  logic                 pixclk,
   input  logic                 reset,
   d5m_pattern_gen_if.master    bus,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEAD   = 3'd1,
      S_LINE   = 3'd2,
      S_HBLANK = 3'd3,
      S_VBLANK = 3'd4
   } state_t;

   localparam int XW   = $clog2(IMG_WIDTH);
   localparam int YW   = $clog2(IMG_HEIGHT);
   localparam int MAXB = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int BW   = $clog2(MAXB + 1);

   localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
   localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
   localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

   localparam logic [DATA_WIDTH-1:0] PIX_M = '1;
   localparam logic [DATA_WIDTH-1:0] PIX_H = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] PIX_B = PIX_H >> 1;

   state_t                state;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [BW-1:0]         blank;
   logic [1:0]            pat_r;
   logic [DATA_WIDTH-1:0] run_pix;
   logic [DATA_WIDTH-1:0] start_pix;
   int                    start_y;

   assign state_dbg = state;

   function automatic logic [DATA_WIDTH-1:0] base_pix(input int px, input int py,
                                                      input logic [1:0] pat);
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      case (pat)
         2'd0: v = DATA_WIDTH'(px);
         2'd1: v = DATA_WIDTH'(py);
         2'd2: begin
            // GRBG mosaic: G on even/even and odd/odd sites
            if (py[0] == 1'b0) v = px[0] ? PIX_M : PIX_H;
            else               v = px[0] ? PIX_H : PIX_B;
         end
         default: begin
`ifndef D5M_PATTERN_LFSR_EN
            v = (((px >> 3) ^ (py >> 3)) & 1) != 0 ? PIX_M : '0;
`endif
         end
      endcase
      return v;
   endfunction

`ifdef D5M_PATTERN_LFSR_EN
   // Maximal-length tap masks (bit n-1 set for tap n); widths below 3 are not supported.
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         default: return 32'h3 << (w - 2);
      endcase
   endfunction

   localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

   logic [DATA_WIDTH-1:0] lfsr;
   logic [DATA_WIDTH-1:0] lfsr_nxt;
`endif

   // Pixel for the next LINE cycle (run) and for the first pixel of a line (start).
   always_comb begin
      start_y   = (state == S_LEAD) ? 0 : int'(y) + 1;
      run_pix   = base_pix(int'(x) + 1, int'(y), pat_r);
      start_pix = base_pix(0, start_y, pat_r);
`ifdef D5M_PATTERN_LFSR_EN
      lfsr_nxt = {lfsr[DATA_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
      if (pat_r == 2'd3) begin
         run_pix   = lfsr_nxt;
         start_pix = lfsr;
      end
`endif
   end

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         x              <= '0;
         y              <= '0;
         blank          <= '0;
         pat_r          <= '0;
         bus.ifval      <= 1'b0;
         bus.ilval      <= 1'b0;
         bus.idata      <= '0;
         bus.frame_done <= 1'b0;
         bus.frame_cnt  <= '0;
`ifdef D5M_PATTERN_LFSR_EN
         lfsr           <= '0;
`endif
      end else begin
         bus.frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.enable) begin
                  state     <= S_LEAD;
                  bus.ifval <= 1'b1;
                  blank     <= '0;
                  pat_r     <= bus.pattern_sel;
`ifdef D5M_PATTERN_LFSR_EN
                  lfsr      <= DATA_WIDTH'(1);
`endif
               end
            end
            S_LEAD: begin
               if (blank == HB_LAST) begin
                  state     <= S_LINE;
                  x         <= '0;
                  y         <= '0;
                  bus.ilval <= 1'b1;
                  bus.idata <= start_pix;
               end else begin
                  blank <= blank + BW'(1);
               end
            end
            S_LINE: begin
`ifdef D5M_PATTERN_LFSR_EN
               lfsr <= lfsr_nxt;
`endif
               if (x == X_LAST) begin
                  state     <= S_HBLANK;
                  blank     <= '0;
                  bus.ilval <= 1'b0;
                  bus.idata <= '0;
               end else begin
                  x         <= x + XW'(1);
                  bus.idata <= run_pix;
               end
            end
            S_HBLANK: begin
               if (blank == HB_LAST) begin
                  if (y == Y_LAST) begin
                     state          <= S_VBLANK;
                     blank          <= '0;
                     bus.ifval      <= 1'b0;
                     bus.frame_done <= 1'b1;
                     bus.frame_cnt  <= bus.frame_cnt + 16'd1;
                  end else begin
                     state     <= S_LINE;
                     x         <= '0;
                     y         <= y + YW'(1);
                     bus.ilval <= 1'b1;
                     bus.idata <= start_pix;
                  end
               end else begin
                  blank <= blank + BW'(1);
               end
            end
            S_VBLANK: begin
               if (blank == VB_LAST) begin
                  blank <= '0;
                  if (bus.enable) begin
                     state     <= S_LEAD;
                     bus.ifval <= 1'b1;
                     pat_r     <= bus.pattern_sel;
`ifdef D5M_PATTERN_LFSR_EN
                     lfsr      <= DATA_WIDTH'(1);
`endif
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  blank <= blank + BW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_d5m_pattern_gen.sv
// Bench for d5m_pattern_gen: per-cycle stream scoreboard from a frame-level model, plus pixel tables.
// Build with D5M_PATTERN_LFSR_EN defined to exercise the LFSR flavour of pattern 3.
module tb_d5m_pattern_gen;

   localparam int DW        = 12;
   localparam int IW        = 8;
   localparam int IH        = 4;
   localparam int HB        = 4;
   localparam int VB        = 6;
   localparam int FV_LEN    = HB + IH * (IW + HB);
   localparam int FRAME_LEN = FV_LEN + VB;
   localparam int SBW       = DW + 3;

   logic       pixclk = 1'b0;
   logic       reset;
   logic [2:0] state_dbg;

   d5m_pattern_gen_if #(.DATA_WIDTH(DW)) bus ();

   d5m_pattern_gen #(
      .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .H_BLANK(HB), .V_BLANK(VB)
   ) dut (
      .pixclk    (pixclk),
      .reset     (reset),
      .bus       (bus.master),
      .state_dbg (state_dbg)
   );

   // clock / watchdog
   always #5 pixclk = ~pixclk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;

   logic [SBW-1:0]  exp_q[$];
   logic [DW-1:0]   cap[IH][IW];
   logic [15:0]     exp_cnt;
   logic [DW-1:0]   ref_lfsr;

   typedef struct {
      int          pat;
      int          x;
      int          y;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference pixel from the pattern definitions (pattern 3 LFSR handled in model_frame).
   function automatic logic [DW-1:0] model_pix(input int p, input int px, input int py);
      logic [DW-1:0] h;
      h = 1 << (DW - 1);
      case (p)
         0: return DW'(px);
         1: return DW'(py);
         2: begin
            if (py % 2 == 0) return (px % 2 == 0) ? h : '1;
            else             return (px % 2 == 0) ? (h >> 1) : h;
         end
         default: return (((px / 8) + (py / 8)) % 2 == 1) ? '1 : '0;
      endcase
   endfunction

   // Push one whole frame (fval high + vblank) as expected {ifval, ilval, frame_done, idata}.
   task automatic model_frame(input int p);
      logic [DW-1:0] pix;
      ref_lfsr = 1;
      repeat (HB) exp_q.push_back({3'b100, {DW{1'b0}}});
      for (int ly = 0; ly < IH; ly++) begin
         for (int lx = 0; lx < IW; lx++) begin
            pix = model_pix(p, lx, ly);
`ifdef D5M_PATTERN_LFSR_EN
            if (p == 3) begin
               pix      = ref_lfsr;
               ref_lfsr = {ref_lfsr[DW-2:0], ^(ref_lfsr & 12'h829)};
            end
`endif
            exp_q.push_back({3'b110, pix});
         end
         repeat (HB) exp_q.push_back({3'b100, {DW{1'b0}}});
      end
      exp_q.push_back({3'b001, {DW{1'b0}}});
      repeat (VB - 1) exp_q.push_back({3'b000, {DW{1'b0}}});
      exp_cnt = exp_cnt + 16'd1;
   endtask

   // Consume one frame from the DUT; junk pattern_sel while fval is high, p_next during vblank.
   task automatic run_frame(input int p_next, input int drop_at);
      int waited;
      logic [SBW-1:0] act;
      logic [SBW-1:0] exp;
      int li;
      int xi;
      waited = 0;
      for (int a = 0; a < IH; a++)
         for (int b = 0; b < IW; b++) cap[a][b] = 12'hABC;
      while (bus.ifval !== 1'b1 && waited < 100) begin
         @(negedge pixclk);
         waited++;
      end
      check("frame_start", {31'd0, bus.ifval}, 32'd1);
      if (bus.ifval !== 1'b1) begin
         exp_q.delete();
         return;
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
         act = {bus.ifval, bus.ilval, bus.frame_done, bus.idata};
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : {SBW{1'b1}};
         check($sformatf("stream[%0d]", i), 32'(act), 32'(exp));
         if (bus.ilval === 1'b1 && i >= HB) begin
            li = (i - HB) / (IW + HB);
            xi = (i - HB) % (IW + HB);
            if (li < IH && xi < IW) cap[li][xi] = bus.idata;
         end
         if (i == FV_LEN) check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
         if (i < FV_LEN) bus.pattern_sel = 2'($urandom_range(0, 3));
         else            bus.pattern_sel = 2'(p_next);
         if (i == drop_at) bus.enable = 1'b0;
         @(negedge pixclk);
      end
   endtask

   task automatic apply_table(input int p);
      foreach (vecs[k]) begin
         if (vecs[k].pat == p)
            check($sformatf("pix_p%0d_x%0d_y%0d", p, vecs[k].x, vecs[k].y),
                  32'(cap[vecs[k].y][vecs[k].x]), 32'(vecs[k].exp));
      end
   endtask

   initial begin
      int p;
      int p_next;
      int waited;

      // pixel vector table
      for (int i = 0; i < IW; i++) vecs.push_back('{0, i, 0, DW'(i)});
      vecs.push_back('{0, 5, 3, 12'h005});
      for (int i = 0; i < IW; i++) vecs.push_back('{1, i, 2, 12'h002});
      vecs.push_back('{1, 6, 0, 12'h000});
      for (int i = 0; i < 4; i++) begin
         vecs.push_back('{2, i, 0, (i % 2 == 0) ? 12'h800 : 12'hFFF});
         vecs.push_back('{2, i, 1, (i % 2 == 0) ? 12'h400 : 12'h800});
      end
`ifdef D5M_PATTERN_LFSR_EN
      vecs.push_back('{3, 0, 0, 12'h001});
      vecs.push_back('{3, 1, 0, 12'h003});
      vecs.push_back('{3, 2, 0, 12'h007});
      vecs.push_back('{3, 3, 0, 12'h00F});
      vecs.push_back('{3, 4, 0, 12'h01E});
`else
      for (int i = 0; i < IW; i++) vecs.push_back('{3, i, 0, 12'h000});
      vecs.push_back('{3, 7, 3, 12'h000});
`endif

      // reset held with enable high
      exp_cnt         = '0;
      reset           = 1'b1;
      bus.enable      = 1'b1;
      bus.pattern_sel = 2'd0;
      repeat (3) @(negedge pixclk);
      check("rst_ifval", {31'd0, bus.ifval}, 32'd0);
      check("rst_ilval", {31'd0, bus.ilval}, 32'd0);
      check("rst_idata", 32'(bus.idata), 32'd0);
      check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
      check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
      reset = 1'b0;
      @(negedge pixclk);
      check("ifval_first_edge", {31'd0, bus.ifval}, 32'd1);

      // directed patterns 0..2, each latched during the previous vblank
      model_frame(0); run_frame(1, -1); apply_table(0);
      model_frame(1); run_frame(2, -1); apply_table(1);
      model_frame(2); run_frame(3, -1); apply_table(2);

      // enable dropped during line 1: frame completes, then idle
      model_frame(3); run_frame(0, HB + (IW + HB) + 4); apply_table(3);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("idle_ifval[%0d]", i), {31'd0, bus.ifval}, 32'd0);
         @(negedge pixclk);
      end
      check("idle_frame_cnt", 32'(bus.frame_cnt), 32'd4);

      // re-enable: ifval rises after one edge, pattern 3 repeats identically
      bus.pattern_sel = 2'd3;
      bus.enable      = 1'b1;
      @(negedge pixclk);
      check("reenable_ifval", {31'd0, bus.ifval}, 32'd1);
      p_next = $urandom_range(0, 3);
      model_frame(3); run_frame(p_next, -1); apply_table(3);

      // randomized back-to-back frames with mid-frame pattern_sel noise
      for (int k = 0; k < 6; k++) begin
         p      = p_next;
         p_next = $urandom_range(0, 3);
         model_frame(p);
         run_frame(p_next, -1);
         apply_table(p);
      end

      // reset asserted mid-line drops outputs without a clock edge
      waited = 0;
      while (bus.ilval !== 1'b1 && waited < 100) begin
         @(negedge pixclk);
         waited++;
      end
      check("midline_reached", {31'd0, bus.ilval}, 32'd1);
      reset = 1'b1;
      #1;
      check("async_rst_ifval", {31'd0, bus.ifval}, 32'd0);
      check("async_rst_ilval", {31'd0, bus.ilval}, 32'd0);
      check("async_rst_idata", 32'(bus.idata), 32'd0);
      check("async_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
      @(negedge pixclk);
      check("rst_hold_frame_done", {31'd0, bus.frame_done}, 32'd0);
      reset = 1'b0;
      @(negedge pixclk);
      check("post_rst_ifval", {31'd0, bus.ifval}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
